score_history: RTL and testbench
================================

SCORE_HISTORY -- requirements
Module: score_history

Interface
REQ-001 Parameter W, default 10, width of WPM/accuracy values and of every statistic output.
REQ-002 Parameter DEPTH, default 8, power of two >= 2, number of most-recent results per mode kept for the moving average.
REQ-003 Parameter NMODE, default 2, number of independent game-mode channels; MW = max(1, clog2(NMODE)), SW = W + clog2(DEPTH), CW = clog2(DEPTH)+1.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 mode_sel  in  MW  channel that res_valid/clear apply to.
REQ-007 res_valid  in  1  one-cycle pulse: finished run's result is on res_wpm/res_acc.
REQ-008 res_wpm  in  W  unsigned WPM of finished run.
REQ-009 res_acc  in  W  unsigned accuracy of finished run.
REQ-010 clear  in  1  pulse: wipe history and statistics of channel mode_sel.
REQ-011 rd_mode  in  MW  channel presented on the statistic outputs.
REQ-012 busy  out  1  update/division in progress; new results not accepted.
REQ-013 overrun  out  1  sticky: a res_valid was dropped.
REQ-014 wpm_best, acc_best, wpm_avg, acc_avg  out  W each  statistics of channel rd_mode.
REQ-015 count  out  CW  number of results in rd_mode's history, 0..DEPTH.

Function
REQ-016 Per channel: ring buffer of DEPTH {wpm,acc} entries, write pointer, count, SW-bit wpm_sum and acc_sum, best and average registers.
REQ-017 FSM states IDLE, UPDATE, DIV_WPM, DIV_ACC; reset state IDLE.
REQ-018 IDLE: res_valid with valid mode_sel and clear=0 is accepted; latch channel, go to UPDATE.
REQ-019 UPDATE (1 cycle): write entry at pointer, pointer increments modulo DEPTH, count increments saturating at DEPTH, sum += new - evicted (evicted = overwritten entry when count was DEPTH, else 0), best = new if new > best (equal keeps old), then go to DIV_WPM.
REQ-020 DIV_WPM and DIV_ACC each last exactly SW cycles; averages = floor(sum / count), written to the channel at the last DIV_ACC cycle; then IDLE.
REQ-021 busy is high in every non-IDLE state: exactly 1 + 2*SW cycles per accepted result (27 at defaults); first result visible at outputs the cycle after busy falls.
REQ-022 res_valid while busy is dropped and sets overrun; overrun cleared only by reset or by any accepted clear.
REQ-023 clear in IDLE zeros the selected channel's buffer pointer, count, sums, bests and averages in one cycle; clear and res_valid together in IDLE: clear wins, result dropped, overrun cleared not set; clear while busy is ignored.
REQ-024 mode_sel >= NMODE: res_valid and clear ignored with no flag; rd_mode >= NMODE: outputs read 0.
REQ-025 Statistic outputs are a combinational mux of registered per-channel state; outputs of a channel never change outside UPDATE/last DIV_ACC cycle/clear.
REQ-026 Division by count never sees 0 (count >= 1 after UPDATE); quotient fits W bits because sum <= count*(2^W-1).

Reset
REQ-027 rst low: FSM to IDLE, busy 0, overrun 0, every channel's pointer, count, sums, bests, averages and buffer entries to 0, immediately and regardless of clock.
REQ-028 Reset mid-division abandons the operation; no partial average is ever written.

Structure
REQ-029 Shared package holds the FSM state enum and the derived widths SW, CW, MW helpers.
REQ-030 One sub-module: seq_divider, restoring serial unsigned divider (SW-bit dividend, CW-bit divisor, W-bit quotient), start/done handshake, one quotient bit per cycle, reused for both divisions.

Verification
REQ-031 Reset, then rd_mode=0 -> all outputs 0, busy 0, count 0.
REQ-032 Mode 0 results (40,90),(50,80),(61,95) spaced 30 cycles -> wpm_best 61, acc_best 95, wpm_avg 50, acc_avg 88, count 3; busy exactly 27 cycles each.
REQ-033 Ten results wpm 10,20..100, acc 50 each into mode 1 -> count 8, wpm_avg 65 (30..100), wpm_best 100, acc_avg 50; mode 0 unchanged.
REQ-034 Second res_valid 5 cycles after first -> dropped, overrun 1, count reflects only first; subsequent clear -> overrun 0, channel zeroed.
REQ-035 clear and res_valid same cycle in IDLE -> channel zeroed, result not stored, overrun 0.
REQ-036 rst low during DIV_ACC -> all outputs 0 asynchronously, busy 0, next result processes normally.

Source files
------------

// File: rtl/score_history_pkg.sv
// score_history_pkg
// Shared types and width helpers for the score history block.
//   state_e  : controller FSM states
//   calc_sw  : width of a per-channel running sum
//   calc_cw  : width of a history count (0..DEPTH)
//   calc_mw  : width of a channel select
//   calc_pw  : width of a ring-buffer pointer
package score_history_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UPDATE  = 2'd1,
        ST_DIV_WPM = 2'd2,
        ST_DIV_ACC = 2'd3
    } state_e;

    function automatic int calc_sw(input int w, input int depth);
        return w + $clog2(depth);
    endfunction

    function automatic int calc_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int calc_mw(input int nmode);
        return (nmode > 1) ? $clog2(nmode) : 1;
    endfunction

    function automatic int calc_pw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/score_history_seq_divider.sv
// seq_divider
// Restoring serial unsigned divider, one quotient bit per cycle, SW cycles
// per division. The first step is taken in the start cycle directly from
// the operands; the final quotient is presented combinationally together
// with done_o in the last step cycle so the caller can capture it on that
// edge.
//   clk, rst      : clock, async active-low reset
//   start_i       : pulse, operands valid, begin division
//   dividend_i    : SW-bit dividend
//   divisor_i     : CW-bit divisor (never 0 when used)
//   quotient_o    : W-bit quotient, valid while done_o is high
//   done_o        : high during the last step cycle
module seq_divider #(
    parameter int SW = 13,
    parameter int CW = 4,
    parameter int W  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] dividend_i,
    input  logic [CW-1:0] divisor_i,
    output logic [W-1:0]  quotient_o,
    output logic          done_o
);

    localparam int TW = $clog2(SW + 1);

    logic [CW-1:0] rem_q, rem_d;
    logic [SW-1:0] quo_q, quo_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic [CW-1:0] src_rem;
    logic [SW-1:0] src_quo;
    logic [CW:0]   shifted;
    logic          ge;
    logic [CW-1:0] diff;

    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        shifted = {src_rem, src_quo[SW-1]};
        ge      = shifted >= {1'b0, divisor_i};
        // When ge holds the true difference is below divisor, so the
        // CW-bit wrapped subtraction is exact.
        diff    = shifted[CW-1:0] - divisor_i;
        rem_d   = ge ? diff : shifted[CW-1:0];
        quo_d   = {src_quo[SW-2:0], ge};
        if (start_i) begin
            cnt_d = TW'(SW - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    assign quotient_o = quo_d[W-1:0];
    assign done_o     = !start_i && (cnt_q == TW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start_i || cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_history.sv
// score_history
// Per game-mode history of typing results: last DEPTH {wpm,acc} entries,
// running sums, lifetime bests and moving averages.
//   clk, rst              : clock, async active-low reset
//   mode_sel              : channel for res_valid / clear
//   res_valid, res_wpm,   : one-cycle result pulse and values
//   res_acc
//   clear                 : wipe channel mode_sel (IDLE only)
//   rd_mode               : channel shown on the statistic outputs
//   busy, overrun         : update in progress / sticky dropped-result flag
//   wpm_best, acc_best,   : statistics of rd_mode (0 if rd_mode invalid)
//   wpm_avg, acc_avg, count
//
// state      | meaning
// ST_IDLE    | waiting for a result or clear
// ST_UPDATE  | write ring entry, update pointer/count/sums/bests
// ST_DIV_WPM | serial division wpm_sum / count
// ST_DIV_ACC | serial division acc_sum / count, averages written at end
module score_history
    import score_history_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter int NMODE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [calc_mw(NMODE)-1:0]   mode_sel,
    input  logic                        res_valid,
    input  logic [W-1:0]                res_wpm,
    input  logic [W-1:0]                res_acc,
    input  logic                        clear,
    input  logic [calc_mw(NMODE)-1:0]   rd_mode,
    output logic                        busy,
    output logic                        overrun,
    output logic [W-1:0]                wpm_best,
    output logic [W-1:0]                acc_best,
    output logic [W-1:0]                wpm_avg,
    output logic [W-1:0]                acc_avg,
    output logic [calc_cw(DEPTH)-1:0]   count
);

    localparam int MW = calc_mw(NMODE);
    localparam int SW = calc_sw(W, DEPTH);
    localparam int CW = calc_cw(DEPTH);
    localparam int PW = calc_pw(DEPTH);
    localparam logic [MW:0] NM_EXT = (MW + 1)'(NMODE);

    state_e         state_q, state_d;
    logic           start_q, start_d;
    logic [MW-1:0]  ch_q;
    logic [W-1:0]   nw_q, na_q, wq_tmp_q;
    logic           overrun_q;

    logic [W-1:0]   buf_w_q [NMODE][DEPTH];
    logic [W-1:0]   buf_a_q [NMODE][DEPTH];
    logic [PW-1:0]  ptr_q   [NMODE];
    logic [CW-1:0]  cnt_q   [NMODE];
    logic [SW-1:0]  wsum_q  [NMODE];
    logic [SW-1:0]  asum_q  [NMODE];
    logic [W-1:0]   wbest_q [NMODE];
    logic [W-1:0]   abest_q [NMODE];
    logic [W-1:0]   wavg_q  [NMODE];
    logic [W-1:0]   aavg_q  [NMODE];

    logic [MW:0]    sel_ext, rd_ext;
    logic           idle, sel_ok, rd_ok, accept, do_clear, drop;
    logic [PW-1:0]  wp;
    logic           full;
    logic [W-1:0]   evict_w, evict_a;
    logic [SW-1:0]  div_dividend;
    logic [CW-1:0]  div_divisor;
    logic [W-1:0]   div_quo;
    logic           div_done;

    assign sel_ext  = {1'b0, mode_sel};
    assign rd_ext   = {1'b0, rd_mode};
    assign sel_ok   = sel_ext < NM_EXT;
    assign rd_ok    = rd_ext < NM_EXT;
    assign idle     = (state_q == ST_IDLE);
    // clear has priority over a simultaneous result
    assign do_clear = idle && clear && sel_ok;
    assign accept   = idle && res_valid && sel_ok && !clear;
    assign drop     = !idle && res_valid && sel_ok;

    assign wp      = ptr_q[ch_q];
    assign full    = (cnt_q[ch_q] == CW'(DEPTH));
    assign evict_w = full ? buf_w_q[ch_q][wp] : '0;
    assign evict_a = full ? buf_a_q[ch_q][wp] : '0;

    assign div_dividend = (state_q == ST_DIV_ACC) ? asum_q[ch_q] : wsum_q[ch_q];
    assign div_divisor  = cnt_q[ch_q];

    seq_divider #(.SW(SW), .CW(CW), .W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_q),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quo),
        .done_o     (div_done)
    );

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d = ST_DIV_WPM;
                start_d = 1'b1;
            end
            ST_DIV_WPM: if (div_done) begin
                state_d = ST_DIV_ACC;
                start_d = 1'b1;
            end
            ST_DIV_ACC: if (div_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            ch_q      <= '0;
            nw_q      <= '0;
            na_q      <= '0;
            wq_tmp_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NMODE; i++) begin
                ptr_q[i]   <= '0;
                cnt_q[i]   <= '0;
                wsum_q[i]  <= '0;
                asum_q[i]  <= '0;
                wbest_q[i] <= '0;
                abest_q[i] <= '0;
                wavg_q[i]  <= '0;
                aavg_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    buf_w_q[i][j] <= '0;
                    buf_a_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            start_q <= start_d;

            if (accept) begin
                ch_q <= mode_sel;
                nw_q <= res_wpm;
                na_q <= res_acc;
            end

            if (do_clear) begin
                overrun_q <= 1'b0;
            end else if (drop) begin
                overrun_q <= 1'b1;
            end

            if (do_clear) begin
                ptr_q[mode_sel]   <= '0;
                cnt_q[mode_sel]   <= '0;
                wsum_q[mode_sel]  <= '0;
                asum_q[mode_sel]  <= '0;
                wbest_q[mode_sel] <= '0;
                abest_q[mode_sel] <= '0;
                wavg_q[mode_sel]  <= '0;
                aavg_q[mode_sel]  <= '0;
            end

            if (state_q == ST_UPDATE) begin
                buf_w_q[ch_q][wp] <= nw_q;
                buf_a_q[ch_q][wp] <= na_q;
                ptr_q[ch_q]       <= wp + PW'(1);
                if (!full) cnt_q[ch_q] <= cnt_q[ch_q] + CW'(1);
                wsum_q[ch_q] <= wsum_q[ch_q] + SW'(nw_q) - SW'(evict_w);
                asum_q[ch_q] <= asum_q[ch_q] + SW'(na_q) - SW'(evict_a);
                if (nw_q > wbest_q[ch_q]) wbest_q[ch_q] <= nw_q;
                if (na_q > abest_q[ch_q]) abest_q[ch_q] <= na_q;
            end

            if (state_q == ST_DIV_WPM && div_done) begin
                wq_tmp_q <= div_quo;
            end

            // both averages land together so a channel never shows a
            // half-updated pair
            if (state_q == ST_DIV_ACC && div_done) begin
                wavg_q[ch_q] <= wq_tmp_q;
                aavg_q[ch_q] <= div_quo;
            end
        end
    end

    assign busy    = !idle;
    assign overrun = overrun_q;

    always_comb begin
        wpm_best = '0;
        acc_best = '0;
        wpm_avg  = '0;
        acc_avg  = '0;
        count    = '0;
        if (rd_ok) begin
            wpm_best = wbest_q[rd_mode];
            acc_best = abest_q[rd_mode];
            wpm_avg  = wavg_q[rd_mode];
            acc_avg  = aavg_q[rd_mode];
            count    = cnt_q[rd_mode];
        end
    end

endmodule

// File: tb/tb_score_history.sv
module tb_score_history;

    localparam int W        = 10;
    localparam int DEPTH    = 8;
    localparam int NMODE    = 2;
    localparam int MW       = 1;
    localparam int CW       = 4;
    localparam int BUSY_CYC = 1 + 2 * (W + $clog2(DEPTH));

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [MW-1:0] mode_sel = '0;
    logic          res_valid = 1'b0;
    logic [W-1:0]  res_wpm = '0;
    logic [W-1:0]  res_acc = '0;
    logic          clear = 1'b0;
    logic [MW-1:0] rd_mode = '0;
    logic          busy, overrun;
    logic [W-1:0]  wpm_best, acc_best, wpm_avg, acc_avg;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    score_history #(.W(W), .DEPTH(DEPTH), .NMODE(NMODE)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_sel  (mode_sel),
        .res_valid (res_valid),
        .res_wpm   (res_wpm),
        .res_acc   (res_acc),
        .clear     (clear),
        .rd_mode   (rd_mode),
        .busy      (busy),
        .overrun   (overrun),
        .wpm_best  (wpm_best),
        .acc_best  (acc_best),
        .wpm_avg   (wpm_avg),
        .acc_avg   (acc_avg),
        .count     (count)
    );

    int total = 0;
    int bad   = 0;

    // reference model: result history per channel as plain lists
    int hw [NMODE][$];
    int ha [NMODE][$];
    int bw [NMODE];
    int ba [NMODE];
    int mbusy;
    bit movr;
    int busy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_avg(input int m, input bit is_acc);
        int s = 0;
        int n;
        n = is_acc ? ha[m].size() : hw[m].size();
        if (n == 0) return 0;
        for (int i = 0; i < n; i++) s += is_acc ? ha[m][i] : hw[m][i];
        return s / n;
    endfunction

    task automatic model_clear(input int m);
        hw[m].delete();
        ha[m].delete();
        bw[m] = 0;
        ba[m] = 0;
    endtask

    // one clock: drive after a falling edge, let the rising edge consume,
    // release inputs and check busy on the next falling edge
    task automatic cycle(input bit rv, input bit clr, input int m, input int w, input int a);
        res_valid = rv;
        clear     = clr;
        mode_sel  = MW'(m);
        res_wpm   = W'(w);
        res_acc   = W'(a);
        if (mbusy == 0) begin
            if (clr) begin
                model_clear(m);
                movr = 1'b0;
            end else if (rv) begin
                hw[m].push_back(w);
                ha[m].push_back(a);
                if (hw[m].size() > DEPTH) begin
                    void'(hw[m].pop_front());
                    void'(ha[m].pop_front());
                end
                if (w > bw[m]) bw[m] = w;
                if (a > ba[m]) ba[m] = a;
                mbusy = BUSY_CYC;
            end
        end else begin
            if (rv) movr = 1'b1;
            mbusy--;
        end
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        clear     = 1'b0;
        if (busy === 1'b1) busy_seen++;
        chk("busy", busy, 32'(mbusy != 0));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic drain();
        while (mbusy != 0) cycle(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check_stats(input int m);
        rd_mode = MW'(m);
        #1;
        chk($sformatf("count_m%0d", m), count, hw[m].size());
        chk($sformatf("wbest_m%0d", m), wpm_best, bw[m]);
        chk($sformatf("abest_m%0d", m), acc_best, ba[m]);
        chk($sformatf("wavg_m%0d", m), wpm_avg, model_avg(m, 1'b0));
        chk($sformatf("aavg_m%0d", m), acc_avg, model_avg(m, 1'b1));
        chk("overrun", overrun, movr);
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < NMODE; m++) begin
            rd_mode = MW'(m);
            #1;
            chk({tag, "_count"}, count, 0);
            chk({tag, "_wbest"}, wpm_best, 0);
            chk({tag, "_abest"}, acc_best, 0);
            chk({tag, "_wavg"}, wpm_avg, 0);
            chk({tag, "_aavg"}, acc_avg, 0);
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        int wl [3];
        int al [3];
        int op, m, w, a;
        wl = '{40, 50, 61};
        al = '{90, 80, 95};
        mbusy = 0;
        movr  = 1'b0;
        for (int i = 0; i < NMODE; i++) model_clear(i);

        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b1;
        @(negedge clk);

        // three mode-0 results, 30 cycles apart
        for (int k = 0; k < 3; k++) begin
            busy_seen = 0;
            cycle(1'b1, 1'b0, 0, wl[k], al[k]);
            idle(29);
            chk("busy_len", busy_seen, BUSY_CYC);
        end
        check_stats(0);
        chk("r32_wbest", wpm_best, 61);
        chk("r32_abest", acc_best, 95);
        chk("r32_wavg", wpm_avg, 50);
        chk("r32_aavg", acc_avg, 88);
        chk("r32_count", count, 3);

        // ten results into mode 1: window wraps
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 1, 10 * k, 50);
            idle(29);
        end
        check_stats(1);
        chk("r33_count", count, 8);
        chk("r33_wavg", wpm_avg, 65);
        chk("r33_wbest", wpm_best, 100);
        chk("r33_aavg", acc_avg, 50);
        check_stats(0);

        // result dropped while busy, then clear
        cycle(1'b0, 1'b1, 0, 0, 0);
        idle(1);
        cycle(1'b1, 1'b0, 0, 300, 70);
        idle(4);
        cycle(1'b1, 1'b0, 0, 400, 20);
        drain();
        check_stats(0);
        chk("r34_ovr", overrun, 1);
        chk("r34_count", count, 1);
        chk("r34_wavg", wpm_avg, 300);
        cycle(1'b0, 1'b1, 0, 0, 0);
        idle(1);
        check_stats(0);
        chk("r34_ovr_clr", overrun, 0);
        chk("r34_count_clr", count, 0);

        // clear together with result in IDLE
        cycle(1'b1, 1'b1, 1, 500, 500);
        idle(1);
        check_stats(1);
        chk("r35_count", count, 0);
        chk("r35_wbest", wpm_best, 0);

        // clear while busy is ignored
        cycle(1'b1, 1'b0, 0, 77, 33);
        idle(3);
        cycle(1'b0, 1'b1, 0, 0, 0);
        drain();
        check_stats(0);
        chk("busy_clr_count", count, 1);

        // reset in the middle of DIV_ACC
        cycle(1'b1, 1'b0, 1, 123, 45);
        idle(20);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        mbusy = 0;
        movr  = 1'b0;
        for (int i = 0; i < NMODE; i++) model_clear(i);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1, 200, 60);
        drain();
        check_stats(1);
        chk("postrst_wavg", wpm_avg, 200);
        check_stats(0);

        // randomized traffic, gaps sometimes shorter than the busy window
        repeat (250) begin
            op = $urandom_range(0, 9);
            m  = $urandom_range(0, NMODE - 1);
            w  = ($urandom_range(0, 3) == 0) ? (1 << W) - 1 : $urandom_range(0, (1 << W) - 1);
            a  = ($urandom_range(0, 3) == 0) ? (1 << W) - 1 : $urandom_range(0, (1 << W) - 1);
            if (op < 7)       cycle(1'b1, 1'b0, m, w, a);
            else if (op == 7) cycle(1'b0, 1'b1, m, 0, 0);
            else if (op == 8) cycle(1'b1, 1'b1, m, w, a);
            else              idle(1);
            idle($urandom_range(0, 34));
            if (mbusy == 0) begin
                check_stats(0);
                check_stats(1);
            end
        end
        drain();
        check_stats(0);
        check_stats(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
